// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of {pc, instr} entries
// Flush has priority over push and pop; pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, credit-limited imem requests, buffered decode handoff
// FETCH_BYPASS_EN: forward a response straight to decode when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, head;
  logic          issue, grant, keep_resp, bypass;
  logic [31:0]   target_pc;
  logic          unused_redirect_lsbs;

  // Credits: an answered request must always find a free buffer slot.
  assign issue = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                 ((32'(fifo_count) + 32'(outstanding_q)) < 32'(FIFO_DEPTH));

  assign imem_req  = issue & ~redirect_valid & ~reset;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;
  assign keep_resp = imem_rvalid & (discard_q == '0) & ~redirect_valid;

  assign target_pc            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + OW'(grant) - OW'(imem_rvalid);
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      discard_d  = outstanding_q - OW'(imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid) begin
        if (discard_q != '0) discard_d = discard_q - OW'(1);
        else                 resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef FETCH_BYPASS_EN
  assign bypass     = fifo_empty & keep_resp;
  assign head       = bypass ? fetch_entry_t'{pc: resp_pc_q, instr: imem_rdata} : fifo_head;
  assign inst_valid = (~fifo_empty | bypass) & ~reset;
`else
  assign bypass     = 1'b0;
  assign head       = fifo_head;
  assign inst_valid = ~fifo_empty & ~reset;
`endif

  assign inst_data = inst_valid ? head.instr : '0;
  assign inst_pc   = inst_valid ? head.pc    : '0;
  assign fifo_push = keep_resp & ~(bypass & inst_ready);
  assign fifo_pop  = inst_valid & inst_ready & ~fifo_empty;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fetch_entry_t'{pc: resp_pc_q, instr: imem_rdata}),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a 1-cycle-latency memory model
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] pending[$];
  logic [63:0] exp_q[$];
  bit          rsp_hold;
  int          max_pend;

  always #5 clk = ~clk;

  fetch_unit #(
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  task automatic expect_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = base + 32'(4 * i);
      exp_q.push_back({pc, pc ^ 32'hA5A5_0000});
    end
  endtask

  task automatic sb_flush();
    exp_q.delete();
  endtask

  // One clock cycle: present this cycle's response, record a grant, advance.
  task automatic step();
    if (reset) begin
      pending.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else if (!rsp_hold && pending.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pending[0] ^ 32'hA5A5_0000;
      void'(pending.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      pending.push_back(imem_addr);
      if (pending.size() > max_pend) max_pend = pending.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (!reset && !redirect_valid && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected act=%h_%h exp=none", inst_pc, inst_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_inst", {inst_pc, inst_data}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    rsp_hold = 1'b0; max_pend = 0;
    @(posedge clk); #1;
    step(); #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_zero", {inst_pc, inst_data}, 64'd0);

    // Streaming from reset, decode always ready
    reset = 1'b0;
    sb_flush(); expect_stream(32'h0, 100);
    #1;
    chk("rel_addr", 64'(imem_addr), 64'd0);
    chk("rel_req", 64'(imem_req), 64'd1);
    run(8);
    chk("stream_max_outstanding", 64'(max_pend), 64'd1);

    // Grant withheld for 5 cycles: request and address must hold
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 64'(imem_req), 64'd1);
      chk("stall_addr", 64'(imem_addr), 64'h20);
      step();
    end
    imem_gnt = 1'b1;
    step();
    chk("stall_release_addr", 64'(imem_addr), 64'h24);

    // Two outstanding, then redirect to 0x40
    rsp_hold = 1'b1;
    step();
    chk("two_outstanding_noreq", 64'(imem_req), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir_req_low", 64'(imem_req), 64'd0);
    sb_flush(); expect_stream(32'h40, 100);
    step();
    redirect_valid = 1'b0; rsp_hold = 1'b0;
    #1;
    chk("redir_valid_next", 64'(inst_valid), 64'd0);
    chk("redir_addr_next", 64'(imem_addr), 64'h40);
    chk("redir_max_outstanding", 64'(max_pend), 64'd2);
    run(8);

    // Redirect to unaligned 0x43 alongside a response and a decode pop
    chk("pre_redir2_valid", 64'(inst_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    sb_flush(); expect_stream(32'h40, 100);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir2_valid_next", 64'(inst_valid), 64'd0);
    chk("redir2_addr_next", 64'(imem_addr), 64'h40);
    run(10);

    // Fill to exactly four entries with decode stalled
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    sb_flush(); expect_stream(32'h0, 100);
    inst_ready = 1'b0;
    run(8);
    chk("full_req_low", 64'(imem_req), 64'd0);
    chk("full_addr", 64'(imem_addr), 64'h10);
    chk("full_head", {inst_pc, inst_data}, {32'h0, 32'hA5A5_0000});
    run(3);
    chk("full_head_stable", {31'd0, inst_valid, inst_pc}, {31'd0, 1'b1, 32'h0});
    inst_ready = 1'b1;
    run(10);

    // Reset with a full buffer
    inst_ready = 1'b0;
    run(8);
    chk("pre_rst_valid", 64'(inst_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_req", 64'(imem_req), 64'd0);
    chk("rst_mid_valid", 64'(inst_valid), 64'd0);
    step();
    chk("rst_next_valid", 64'(inst_valid), 64'd0);
    chk("rst_next_req", 64'(imem_req), 64'd0);
    chk("rst_next_addr", 64'(imem_addr), 64'd0);
    step();
    reset = 1'b0;
    sb_flush(); expect_stream(32'h0, 100);
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && !inst_valid; i++) step();
    chk("post_rst_first_pc", {31'd0, inst_valid, inst_pc}, {31'd0, 1'b1, 32'h0});
    run(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
